instr_fetch_unit: RTL and testbench

- Consumes the next-PC produced by the PC/branch stage. Issues instruction-memory read requests and buffers the returned 32-bit instructions with their PCs. Hands them to decode over a valid/ready interface.
- Supports multiple outstanding memory requests and a prefetch queue.
- On a redirect (taken branch), flushes the queue and discards in-flight stale responses.

---
 rtl/ifu_pkg.sv | 15 +
 rtl/ifu_fifo.sv | 56 +++++
 rtl/instr_fetch_unit.sv | 142 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional feature macro: IFU_MISALIGN_CHECK_EN (see instr_fetch_unit.sv).
package ifu_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] PC_STEP          = 64'd4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'd0;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Prefetch queue: synchronous FIFO of fetched {pc, instr} entries with a
// single-cycle flush used when fetch is redirected.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  fetch_entry_t             i_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output fetch_entry_t             o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   r_mem [DEPTH];
    logic [AW-1:0]  r_wrPtr;
    logic [AW-1:0]  r_rdPtr;
    logic [AW:0]    r_count;

    // Pointers and occupancy; a flush discards everything, including a same-cycle push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (i_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            r_count <= r_count + {{AW{1'b0}}, i_push} - {{AW{1'b0}}, i_pop};
        end
    end

    // Storage array; contents need no reset because r_count gates visibility
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    assign o_head  = r_mem[r_rdPtr];
    assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues in-order imem reads with a credit limit,
// buffers responses with their PCs and hands them to decode. A redirect
// flushes the queue and marks every in-flight response as stale.
// Optional feature macro: IFU_MISALIGN_CHECK_EN adds misalign_err and halts
// fetching after a redirect to a non-word-aligned target.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = RESET_PC_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [XLEN-1:0]  imem_req_addr,
    input  logic             imem_resp_valid,
    input  logic [ILEN-1:0]  imem_resp_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ILEN-1:0]  out_instr,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  fetch_pc
`ifdef IFU_MISALIGN_CHECK_EN
    ,
    output logic             misalign_err
`endif
);

    localparam int             CW        = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]  DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0]  MAX_OUT_C = CW'(MAX_OUTSTANDING);

    logic [XLEN-1:0] r_fetchPc;
    logic [XLEN-1:0] r_respPc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_dropCnt;

    logic [CW-1:0]   w_count;
    logic [CW-1:0]   w_credit;
    logic [CW-1:0]   w_reqInc;
    logic [CW-1:0]   w_respDec;
    logic            w_reqFire;
    logic            w_respFire;
    logic            w_drop;
    logic            w_push;
    logic            w_pop;
    logic            w_halt;
    logic [XLEN-1:0] w_targetPc;
    fetch_entry_t    w_pushData;
    fetch_entry_t    w_head;

`ifdef IFU_MISALIGN_CHECK_EN
    logic r_misalignErr;

    // Every redirect re-evaluates alignment: misaligned sets the error, aligned clears it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_misalignErr <= 1'b0;
        end else if (redirect_valid) begin
            r_misalignErr <= (redirect_pc[1:0] != 2'b00);
        end
    end

    assign misalign_err = r_misalignErr;
    assign w_halt       = r_misalignErr;
    assign w_targetPc   = redirect_pc;
`else
    assign w_halt       = 1'b0;
    assign w_targetPc   = redirect_pc & ~(XLEN'(3));
`endif

    // A response with nothing outstanding is ignored rather than corrupting the counters
    assign w_respFire = imem_resp_valid && (r_outstanding != '0);
    assign w_drop     = (r_dropCnt != '0);
    assign w_push     = w_respFire && !w_drop && !redirect_valid;

    // Credit check covers both queue space and in-flight responses, so a push never overflows
    assign w_credit       = r_outstanding + w_count;
    assign imem_req_valid = reset && !redirect_valid && !w_halt &&
                            (r_outstanding < MAX_OUT_C) && (w_credit < DEPTH_C);
    assign imem_req_addr  = r_fetchPc;
    assign w_reqFire      = imem_req_valid && imem_req_ready;

    assign out_valid = (w_count != '0) && !redirect_valid;
    assign w_pop     = out_valid && out_ready;
    assign out_instr = w_head.instr;
    assign out_pc    = w_head.pc;
    assign fetch_pc  = r_fetchPc;

    assign w_reqInc   = {{(CW-1){1'b0}}, w_reqFire};
    assign w_respDec  = {{(CW-1){1'b0}}, w_respFire};
    assign w_pushData = '{pc: r_respPc, instr: imem_resp_data};

    // PCs and request accounting; on a redirect every response still in flight becomes stale
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetchPc     <= RESET_PC;
            r_respPc      <= RESET_PC;
            r_outstanding <= '0;
            r_dropCnt     <= '0;
        end else begin
            r_outstanding <= r_outstanding + w_reqInc - w_respDec;
            if (redirect_valid) begin
                r_fetchPc <= w_targetPc;
                r_respPc  <= w_targetPc;
                r_dropCnt <= r_outstanding - w_respDec;
            end else begin
                if (w_reqFire) begin
                    r_fetchPc <= r_fetchPc + PC_STEP;
                end
                if (w_push) begin
                    r_respPc <= r_respPc + PC_STEP;
                end
                if (w_respFire && w_drop) begin
                    r_dropCnt <= r_dropCnt - 1'b1;
                end
            end
        end
    end

    ifu_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_push),
        .i_data  (w_pushData),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // Responses must only arrive while a request is outstanding
    a_respNeedsReq: assert property (@(posedge clk) disable iff (!reset)
                                     !(imem_resp_valid && (r_outstanding == '0)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: in-order imem model with
// optional response hold, scoreboard of expected {pc, instr} per epoch.
// Optional feature macro: IFU_MISALIGN_CHECK_EN.
module tb_instr_fetch_unit;
    import ifu_pkg::*;

    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic [63:0] fetch_pc;
`ifdef IFU_MISALIGN_CHECK_EN
    logic        misalign_err;
`endif

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAXO),
        .RESET_PC        (64'd0)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .fetch_pc        (fetch_pc)
`ifdef IFU_MISALIGN_CHECK_EN
        ,
        .misalign_err    (misalign_err)
`endif
    );

    typedef struct {
        logic [63:0] addr;
        int          epoch;
    } memReq_t;

    typedef struct {
        logic        rv;
        logic [63:0] rpc;
        logic        reqReady;
        logic        outReady;
        logic        expReqValid;
        logic [63:0] expReqAddr;
        logic        expOutValid;
        logic [63:0] expOutPc;
    } vec_t;

    memReq_t      memQ[$];
    fetch_entry_t expQ[$];
    logic [63:0]  popLog[$];
    int           epoch;
    int           errors = 0;
    int           checks = 0;
    int           popCount;
    int           fireCount;
    logic [63:0]  lastFireAddr;
    logic [63:0]  expFetchPc;
    logic         expHalt;
    logic         ctlReqReady;
    logic         ctlOutReady;
    logic         ctlHold;
    logic         sReqValid;
    logic [63:0]  sReqAddr;
    logic         sOutValid;
    logic [63:0]  sOutPc;
    logic [63:0]  sFetchPc;
    logic         sMisalign;

    function automatic logic [31:0] instrFor(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_0F0F ^ {a[39:32], 24'h0};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs at negedge, check against the model, update the model
    task automatic applyStimulus(input logic rv, input logic [63:0] rpc);
        memReq_t     cur;
        logic        respNow;
        int          inflightNow;
        int          countNow;
        logic        expReqV;
        logic        expOutV;
        fetch_entry_t head;
        @(negedge clk);
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_req_ready = ctlReqReady;
        out_ready      = ctlOutReady;
        inflightNow    = memQ.size();
        countNow       = expQ.size();
        respNow        = 1'b0;
        cur            = '{addr: 64'd0, epoch: 0};
        if (!ctlHold && memQ.size() > 0) begin
            cur             = memQ.pop_front();
            respNow         = 1'b1;
            imem_resp_valid = 1'b1;
            imem_resp_data  = instrFor(cur.addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
        #1;
        sReqValid = imem_req_valid;
        sReqAddr  = imem_req_addr;
        sOutValid = out_valid;
        sOutPc    = out_pc;
        sFetchPc  = fetch_pc;
`ifdef IFU_MISALIGN_CHECK_EN
        sMisalign = misalign_err;
        checkOutput("misalign_err", 64'(misalign_err), 64'(expHalt));
`else
        sMisalign = 1'b0;
`endif
        expReqV = !rv && !expHalt && (inflightNow < MAXO) && (inflightNow + countNow < DEPTH);
        expOutV = (countNow > 0) && !rv;
        checkOutput("req_valid", 64'(imem_req_valid), 64'(expReqV));
        checkOutput("out_valid", 64'(out_valid), 64'(expOutV));
        checkOutput("fetch_pc", fetch_pc, expFetchPc);
        checkOutput("req_addr", imem_req_addr, expFetchPc);
        if (out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pop: got pc 0x%0h expected no output", out_pc);
            end else begin
                head = expQ.pop_front();
                checkOutput("out_pc", out_pc, head.pc);
                checkOutput("out_instr", 64'(out_instr), 64'(head.instr));
            end
            popLog.push_back(out_pc);
            popCount++;
        end
        if (imem_req_valid && imem_req_ready) begin
            memQ.push_back('{addr: imem_req_addr, epoch: epoch});
            lastFireAddr = imem_req_addr;
            fireCount++;
            expFetchPc = expFetchPc + 64'd4;
        end
        if (respNow && !rv && cur.epoch == epoch) begin
            expQ.push_back('{pc: cur.addr, instr: instrFor(cur.addr)});
        end
        if (rv) begin
            expQ.delete();
            epoch++;
`ifdef IFU_MISALIGN_CHECK_EN
            expFetchPc = rpc;
            expHalt    = (rpc[1:0] != 2'b00);
`else
            expFetchPc = rpc & ~64'h3;
`endif
        end
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        out_ready       = 1'b0;
        ctlReqReady     = 1'b1;
        ctlOutReady     = 1'b1;
        ctlHold         = 1'b0;
        memQ.delete();
        expQ.delete();
        popLog.delete();
        epoch        = 0;
        popCount     = 0;
        fireCount    = 0;
        lastFireAddr = '0;
        expFetchPc   = 64'd0;
        expHalt      = 1'b0;
        #1;
        checkOutput("reset_req_valid", 64'(imem_req_valid), 64'd0);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_fetch_pc", fetch_pc, 64'd0);
`ifdef IFU_MISALIGN_CHECK_EN
        checkOutput("reset_misalign", 64'(misalign_err), 64'd0);
`endif
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Bounded wait for the pop or fire counter to reach a target
    task automatic runUntil(input bit usePops, input int target, input int limit, input string name);
        int n = 0;
        while (((usePops ? popCount : fireCount) < target) && n < limit) begin
            applyStimulus(1'b0, 64'd0);
            n++;
        end
        checks++;
        if ((usePops ? popCount : fireCount) < target) begin
            errors++;
            $display("[TB] FAIL %s: timed out after %0d cycles, got %0d need %0d",
                     name, n, usePops ? popCount : fireCount, target);
        end
    endtask

    task automatic checkPopAt(input string name, input int idx, input logic [63:0] exp);
        logic [63:0] act;
        act = (popLog.size() > idx) ? popLog[idx] : 64'hFFFF_FFFF_FFFF_FFFF;
        checkOutput(name, act, exp);
    endtask

    // Bring up two requests (8 and 12) whose responses are held in the memory
    task automatic setupTwoInFlight();
        applyReset();
        applyStimulus(1'b0, 64'd0);
        applyStimulus(1'b0, 64'd0);
        ctlReqReady = 1'b0;
        applyStimulus(1'b0, 64'd0);
        ctlReqReady = 1'b1;
        ctlHold     = 1'b1;
        applyStimulus(1'b0, 64'd0);
        applyStimulus(1'b0, 64'd0);
        checkOutput("two_inflight_last_addr", lastFireAddr, 64'd12);
    endtask

    vec_t tbl[6];

    initial begin
        int base;
        int f;
        logic staleSeen;

        tbl[0] = '{1'b0, 64'd0, 1'b1, 1'b1, 1'b1, 64'd0,  1'b0, 64'd0};
        tbl[1] = '{1'b0, 64'd0, 1'b1, 1'b1, 1'b1, 64'd4,  1'b0, 64'd0};
        tbl[2] = '{1'b0, 64'd0, 1'b1, 1'b1, 1'b1, 64'd8,  1'b1, 64'd0};
        tbl[3] = '{1'b0, 64'd0, 1'b1, 1'b1, 1'b1, 64'd12, 1'b1, 64'd4};
        tbl[4] = '{1'b0, 64'd0, 1'b1, 1'b1, 1'b1, 64'd16, 1'b1, 64'd8};
        tbl[5] = '{1'b0, 64'd0, 1'b1, 1'b1, 1'b1, 64'd20, 1'b1, 64'd12};

        // Sequential fetch, first output two cycles after the first request
        applyReset();
        for (int i = 0; i < 6; i++) begin
            ctlReqReady = tbl[i].reqReady;
            ctlOutReady = tbl[i].outReady;
            applyStimulus(tbl[i].rv, tbl[i].rpc);
            checkOutput($sformatf("tbl%0d_req_valid", i), 64'(sReqValid), 64'(tbl[i].expReqValid));
            checkOutput($sformatf("tbl%0d_req_addr", i), sReqAddr, tbl[i].expReqAddr);
            checkOutput($sformatf("tbl%0d_out_valid", i), 64'(sOutValid), 64'(tbl[i].expOutValid));
            if (tbl[i].expOutValid) begin
                checkOutput($sformatf("tbl%0d_out_pc", i), sOutPc, tbl[i].expOutPc);
            end
        end

        // Backpressure fills the queue and stalls requests at 16
        applyReset();
        ctlOutReady = 1'b0;
        repeat (8) applyStimulus(1'b0, 64'd0);
        checkOutput("bp_fire_count", 64'(fireCount), 64'd4);
        checkOutput("bp_req_valid", 64'(sReqValid), 64'd0);
        checkOutput("bp_fetch_pc", sFetchPc, 64'd16);
        checkOutput("bp_out_valid", 64'(sOutValid), 64'd1);
        ctlOutReady = 1'b1;
        runUntil(1'b0, fireCount + 1, 10, "bp_resume");
        checkOutput("bp_resume_addr", lastFireAddr, 64'd16);
        runUntil(1'b1, 6, 20, "bp_drain");
        checkPopAt("bp_pop4", 4, 64'd16);

        // Redirect with requests to 8 and 12 in flight
        setupTwoInFlight();
        base = popCount;
        applyStimulus(1'b1, 64'h100);
        ctlHold = 1'b0;
        runUntil(1'b1, base + 2, 20, "rd2_drain");
        checkPopAt("rd2_first_pc", base, 64'h100);
        checkPopAt("rd2_second_pc", base + 1, 64'h104);
        staleSeen = 1'b0;
        for (int i = base; i < popLog.size(); i++) begin
            if (popLog[i] == 64'd8 || popLog[i] == 64'd12) staleSeen = 1'b1;
        end
        checkOutput("rd2_no_stale", 64'(staleSeen), 64'd0);

        // Back-to-back redirects: the last target wins
        setupTwoInFlight();
        base = popCount;
        applyStimulus(1'b1, 64'h100);
        applyStimulus(1'b1, 64'h300);
        ctlHold = 1'b0;
        runUntil(1'b1, base + 2, 20, "b2b_drain");
        checkPopAt("b2b_first_pc", base, 64'h300);
        checkPopAt("b2b_second_pc", base + 1, 64'h304);

        // Redirect coincident with the only outstanding response
        applyReset();
        applyStimulus(1'b0, 64'd0);
        ctlReqReady = 1'b0;
        base = popCount;
        applyStimulus(1'b1, 64'h200);
        ctlReqReady = 1'b1;
        runUntil(1'b1, base + 1, 20, "coin_drain");
        checkPopAt("coin_first_pc", base, 64'h200);

        // Backward redirect then sequential
        applyReset();
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b0, 64'd0);
            if (sFetchPc == 64'h40) break;
        end
        checkOutput("bw_reach_40", sFetchPc, 64'h40);
        base = popCount;
        applyStimulus(1'b1, 64'h20);
        runUntil(1'b1, base + 3, 20, "bw_drain");
        checkPopAt("bw_pc0", base, 64'h20);
        checkPopAt("bw_pc1", base + 1, 64'h24);
        checkPopAt("bw_pc2", base + 2, 64'h28);

`ifdef IFU_MISALIGN_CHECK_EN
        // Misaligned redirect halts fetching until an aligned redirect
        applyReset();
        repeat (3) applyStimulus(1'b0, 64'd0);
        applyStimulus(1'b1, 64'h102);
        f = fireCount;
        repeat (5) applyStimulus(1'b0, 64'd0);
        checkOutput("mis_err_set", 64'(sMisalign), 64'd1);
        checkOutput("mis_no_req", 64'(fireCount), 64'(f));
        base = popCount;
        applyStimulus(1'b1, 64'h104);
        applyStimulus(1'b0, 64'd0);
        checkOutput("mis_err_clear", 64'(sMisalign), 64'd0);
        runUntil(1'b1, base + 1, 20, "mis_drain");
        checkPopAt("mis_first_pc", base, 64'h104);
`else
        // Without the check, the low target bits are ignored
        applyReset();
        repeat (3) applyStimulus(1'b0, 64'd0);
        base = popCount;
        applyStimulus(1'b1, 64'h102);
        f = fireCount;
        runUntil(1'b0, f + 1, 10, "align_fire");
        checkOutput("align_first_req", lastFireAddr, 64'h100);
        runUntil(1'b1, base + 1, 20, "align_drain");
        checkPopAt("align_first_pc", base, 64'h100);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
